// File: rtl/cpu_mem_unit.sv
// Program/data memory responder with a built-in program loader that holds the CPU in reset while loading.
// Optional write-to-read forwarding on same-address collisions: define CPU_MEM_WR_FWD_EN.
module cpu_mem_unit #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 2048,
  parameter int START_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              reload,
  output logic [ADDR_W:0]   load_count,
  output logic              cpu_rst_n,
  output logic [ADDR_W-1:0] start_pc,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instr,
  input  logic [ADDR_W-1:0] ram_addr2,
  input  logic [DATA_W-1:0] ram_in2,
  input  logic              mem_w_en,
  output logic [DATA_W-1:0] ram_data2,
  output logic              state_dbg
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  // Load handshake: a word moves when load_valid & load_ready are both high at a
  // rising edge; load_ready is high exactly while in LOAD, load_valid is ignored in RUN.
  typedef enum logic {ST_LOAD = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            state, next_state;
  logic [ADDR_W-1:0] load_ptr;
  logic              hs;
  logic              run;
  logic              pc_ok, a2_ok;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] fetch_word, data_word;
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) state <= ST_LOAD;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    load_ready = 1'b0;
    case (state)
      ST_LOAD: begin
        load_ready = 1'b1;
        if (load_valid && (load_last || load_ptr == LAST_PTR)) next_state = ST_RUN;
      end
      ST_RUN: begin
        if (reload) next_state = ST_LOAD;
      end
      default: next_state = ST_LOAD;
    endcase
  end

  assign hs        = load_valid & load_ready;
  assign run       = (state == ST_RUN);
  assign state_dbg = run;
  assign start_pc  = ADDR_W'(START_PC);
  assign pc_ok     = ({1'b0, pc} < DEPTH_W);
  assign a2_ok     = ({1'b0, ram_addr2} < DEPTH_W);

  always_ff @(posedge clk) begin
    if (rst || (run && reload)) begin
      load_ptr   <= '0;
      load_count <= '0;
    end else if (hs) begin
      load_ptr   <= load_ptr + 1'b1;
      load_count <= (load_count == DEPTH_W) ? load_count : load_count + 1'b1;
    end
  end

  // High from the edge that enters RUN until the edge that samples reload or rst.
  always_ff @(posedge clk) begin
    if (rst) cpu_rst_n <= 1'b0;
    else     cpu_rst_n <= (next_state == ST_RUN);
  end

  // Single write port shared by the loader (LOAD) and the CPU data port (RUN).
  assign wr_en   = !rst && (hs || (run && mem_w_en && a2_ok));
  assign wr_addr = hs ? load_ptr  : ram_addr2;
  assign wr_data = hs ? load_data : ram_in2;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr[IDX_W-1:0]] <= wr_data;
  end

`ifdef CPU_MEM_WR_FWD_EN
  logic wr_run;
  assign wr_run     = run && mem_w_en && a2_ok;
  assign fetch_word = (wr_run && pc == ram_addr2) ? ram_in2 : mem[pc[IDX_W-1:0]];
  assign data_word  = wr_run ? ram_in2 : mem[ram_addr2[IDX_W-1:0]];
`else
  assign fetch_word = mem[pc[IDX_W-1:0]];
  assign data_word  = mem[ram_addr2[IDX_W-1:0]];
`endif

  // Outputs read as zero during LOAD and for addresses beyond DEPTH.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      instr     <= '0;
      ram_data2 <= '0;
    end else begin
      instr     <= pc_ok ? fetch_word : '0;
      ram_data2 <= a2_ok ? data_word  : '0;
    end
  end

endmodule

// File: tb/tb_cpu_mem_unit.sv
// Self-checking bench for cpu_mem_unit: default-size instance plus a DEPTH=8 instance for boundary cases.
module tb_cpu_mem_unit;

  localparam int AW  = 11;
  localparam int DW  = 32;
  localparam int BAW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT A (default parameters) ----------------
  logic          a_load_valid, a_load_ready, a_load_last, a_reload;
  logic [DW-1:0] a_load_data;
  logic [AW:0]   a_load_count;
  logic          a_cpu_rst_n, a_mem_w_en, a_state_dbg;
  logic [AW-1:0] a_start_pc, a_pc, a_ram_addr2;
  logic [DW-1:0] a_instr, a_ram_in2, a_ram_data2;

  cpu_mem_unit #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(2048), .START_PC(0)) u_a (
    .clk(clk), .rst(rst),
    .load_valid(a_load_valid), .load_ready(a_load_ready), .load_data(a_load_data),
    .load_last(a_load_last), .reload(a_reload), .load_count(a_load_count),
    .cpu_rst_n(a_cpu_rst_n), .start_pc(a_start_pc), .pc(a_pc), .instr(a_instr),
    .ram_addr2(a_ram_addr2), .ram_in2(a_ram_in2), .mem_w_en(a_mem_w_en),
    .ram_data2(a_ram_data2), .state_dbg(a_state_dbg)
  );

  // ---------------- DUT B (DEPTH=8, 4-bit addresses) ----------------
  logic           b_load_valid, b_load_ready, b_load_last, b_reload;
  logic [DW-1:0]  b_load_data;
  logic [BAW:0]   b_load_count;
  logic           b_cpu_rst_n, b_mem_w_en, b_state_dbg;
  logic [BAW-1:0] b_start_pc, b_pc, b_ram_addr2;
  logic [DW-1:0]  b_instr, b_ram_in2, b_ram_data2;

  cpu_mem_unit #(.ADDR_W(BAW), .DATA_W(DW), .DEPTH(8), .START_PC(3)) u_b (
    .clk(clk), .rst(rst),
    .load_valid(b_load_valid), .load_ready(b_load_ready), .load_data(b_load_data),
    .load_last(b_load_last), .reload(b_reload), .load_count(b_load_count),
    .cpu_rst_n(b_cpu_rst_n), .start_pc(b_start_pc), .pc(b_pc), .instr(b_instr),
    .ram_addr2(b_ram_addr2), .ram_in2(b_ram_in2), .mem_w_en(b_mem_w_en),
    .ram_data2(b_ram_data2), .state_dbg(b_state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] col_exp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic a_rd(input logic [AW-1:0] p, input logic [AW-1:0] a2,
                      input logic [DW-1:0] ei, input logic [DW-1:0] ed);
    a_pc = p; a_ram_addr2 = a2; a_mem_w_en = 1'b0;
    exp_q.push_back(ei);
    exp_q.push_back(ed);
    step();
    chk("a_instr", a_instr, exp_q.pop_front());
    chk("a_ram_data2", a_ram_data2, exp_q.pop_front());
  endtask

  // Store; the data-port read of the same cycle is compared only when chk_d is set.
  task automatic a_wr(input logic [AW-1:0] a2, input logic [DW-1:0] d, input logic [AW-1:0] p,
                      input logic [DW-1:0] ei, input logic [DW-1:0] ed, input logic chk_d);
    logic [DW-1:0] e;
    a_pc = p; a_ram_addr2 = a2; a_ram_in2 = d; a_mem_w_en = 1'b1;
    exp_q.push_back(ei);
    exp_q.push_back(ed);
    step();
    a_mem_w_en = 1'b0;
    chk("a_wr_instr", a_instr, exp_q.pop_front());
    e = exp_q.pop_front();
    if (chk_d) chk("a_wr_ram_data2", a_ram_data2, e);
  endtask

  // ---------------- load vector table ----------------
  typedef struct {
    logic          valid;
    logic [DW-1:0] data;
    logic          last;
    logic          reload;
    logic [AW:0]   cnt;
    logic          rdy;
    logic          rstn;
    logic [DW-1:0] instr;
    logic [DW-1:0] rd;
  } vec_t;

  vec_t tbl[6];

  initial begin
    `ifdef CPU_MEM_WR_FWD_EN
    col_exp = 32'hCAFEF00D;
    `else
    col_exp = 32'h22;
    `endif

    tbl[0] = '{1'b1, 32'h11, 1'b0, 1'b0, 12'd1, 1'b1, 1'b0, 32'h0,  32'h0};
    tbl[1] = '{1'b0, 32'h55, 1'b1, 1'b1, 12'd1, 1'b1, 1'b0, 32'h0,  32'h0};
    tbl[2] = '{1'b1, 32'h22, 1'b0, 1'b0, 12'd2, 1'b1, 1'b0, 32'h0,  32'h0};
    tbl[3] = '{1'b1, 32'h33, 1'b0, 1'b0, 12'd3, 1'b1, 1'b0, 32'h0,  32'h0};
    tbl[4] = '{1'b1, 32'h44, 1'b1, 1'b0, 12'd4, 1'b0, 1'b1, 32'h0,  32'h0};
    tbl[5] = '{1'b1, 32'h77, 1'b1, 1'b0, 12'd4, 1'b0, 1'b1, 32'h11, 32'h22};

    rst = 1'b1;
    a_load_valid = 1'b0; a_load_data = '0; a_load_last = 1'b0; a_reload = 1'b0;
    a_pc = '0; a_ram_addr2 = '0; a_ram_in2 = '0; a_mem_w_en = 1'b0;
    b_load_valid = 1'b0; b_load_data = '0; b_load_last = 1'b0; b_reload = 1'b0;
    b_pc = '0; b_ram_addr2 = '0; b_ram_in2 = '0; b_mem_w_en = 1'b0;

    @(negedge clk);
    step();
    step();
    chk("rst_load_count", a_load_count, 0);
    chk("rst_cpu_rst_n", a_cpu_rst_n, 0);
    chk("rst_load_ready", a_load_ready, 1);
    chk("rst_instr", a_instr, 0);
    chk("rst_ram_data2", a_ram_data2, 0);
    chk("rst_state", a_state_dbg, 0);
    chk("start_pc_a", a_start_pc, 0);
    chk("start_pc_b", b_start_pc, 3);
    rst = 1'b0;

    // Program load through the table; CPU ports parked on pc=0 / addr2=1.
    a_pc = 11'd0; a_ram_addr2 = 11'd1;
    for (int i = 0; i < 6; i++) begin
      a_load_valid = tbl[i].valid;
      a_load_data  = tbl[i].data;
      a_load_last  = tbl[i].last;
      a_reload     = tbl[i].reload;
      step();
      chk($sformatf("tbl%0d_count", i), a_load_count, tbl[i].cnt);
      chk($sformatf("tbl%0d_ready", i), a_load_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_cpu_rst_n", i), a_cpu_rst_n, tbl[i].rstn);
      chk($sformatf("tbl%0d_instr", i), a_instr, tbl[i].instr);
      chk($sformatf("tbl%0d_ram_data2", i), a_ram_data2, tbl[i].rd);
    end
    a_load_valid = 1'b0; a_load_last = 1'b0; a_reload = 1'b0;

    // RUN reads, store, collision.
    a_rd(11'd2, 11'd3, 32'h33, 32'h44);
    a_rd(11'd3, 11'd0, 32'h44, 32'h11);
    a_wr(11'd5, 32'hDEADBEEF, 11'd2, 32'h33, 32'h0, 1'b0);
    a_rd(11'd5, 11'd5, 32'hDEADBEEF, 32'hDEADBEEF);
    a_wr(11'd1, 32'hCAFEF00D, 11'd1, col_exp, col_exp, 1'b1);
    a_rd(11'd1, 11'd1, 32'hCAFEF00D, 32'hCAFEF00D);

    // Reload, partial load with a rogue store and an ignored reload, then rst mid-load.
    a_reload = 1'b1;
    step();
    a_reload = 1'b0;
    chk("reload_cpu_rst_n", a_cpu_rst_n, 0);
    chk("reload_ready", a_load_ready, 1);
    chk("reload_count", a_load_count, 0);
    a_load_valid = 1'b1; a_load_data = 32'hA0;
    a_mem_w_en = 1'b1; a_ram_addr2 = 11'd5; a_ram_in2 = 32'h0BAD;
    step();
    chk("reld1_count", a_load_count, 1);
    chk("reld1_instr", a_instr, 0);
    a_load_data = 32'hA1; a_reload = 1'b1;
    step();
    chk("reld2_count", a_load_count, 2);
    chk("reld2_ready", a_load_ready, 1);
    a_load_valid = 1'b0; a_reload = 1'b0; a_mem_w_en = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_count", a_load_count, 0);
    chk("midrst_cpu_rst_n", a_cpu_rst_n, 0);
    chk("midrst_ready", a_load_ready, 1);
    a_load_valid = 1'b1; a_load_data = 32'h99; a_load_last = 1'b1;
    step();
    a_load_valid = 1'b0; a_load_last = 1'b0;
    chk("reld_run_cpu_rst_n", a_cpu_rst_n, 1);
    chk("reld_run_count", a_load_count, 1);
    chk("reld_run_ready", a_load_ready, 0);
    a_rd(11'd0, 11'd1, 32'h99, 32'hA1);
    a_rd(11'd5, 11'd2, 32'hDEADBEEF, 32'h33);

    // DEPTH=8 instance: fill without load_last, RUN forced at the last slot.
    for (int i = 0; i < 8; i++) begin
      b_load_valid = 1'b1;
      b_load_data  = 32'h100 + DW'(i);
      step();
      chk($sformatf("b_fill%0d_count", i), b_load_count, 64'(i + 1));
      chk($sformatf("b_fill%0d_ready", i), b_load_ready, (i < 7) ? 64'd1 : 64'd0);
      chk($sformatf("b_fill%0d_cpu_rst_n", i), b_cpu_rst_n, (i == 7) ? 64'd1 : 64'd0);
    end
    b_load_valid = 1'b0;

    b_pc = 4'd7; b_ram_addr2 = 4'd12;
    exp_q.push_back(32'h107);
    exp_q.push_back(32'h0);
    step();
    chk("b_instr_7", b_instr, exp_q.pop_front());
    chk("b_data_oor", b_ram_data2, exp_q.pop_front());

    b_pc = 4'd9; b_ram_addr2 = 4'd10; b_ram_in2 = 32'hBAD0; b_mem_w_en = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    step();
    b_mem_w_en = 1'b0;
    chk("b_instr_oor", b_instr, exp_q.pop_front());
    chk("b_data_oor_wr", b_ram_data2, exp_q.pop_front());

    b_pc = 4'd2; b_ram_addr2 = 4'd2;
    exp_q.push_back(32'h102);
    exp_q.push_back(32'h102);
    step();
    chk("b_instr_alias", b_instr, exp_q.pop_front());
    chk("b_data_alias", b_ram_data2, exp_q.pop_front());

    b_reload = 1'b1;
    step();
    b_reload = 1'b0;
    chk("b_reload_cpu_rst_n", b_cpu_rst_n, 0);
    chk("b_reload_ready", b_load_ready, 1);
    chk("b_reload_count", b_load_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
